hbridge_dir_sequencer: RTL

//  Control-side front end for the deadtime H-bridge driver (pwm_delay). Generates the pwm_in carrier

---
 rtl/hbridge_dir_sequencer_pkg.sv | 19 +
 rtl/hbridge_dir_sequencer_carrier.sv | 37 +++
 rtl/hbridge_dir_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hbridge_dir_sequencer_pkg.sv
// Shared state encoding and state-class helpers for the H-bridge direction sequencer.
package hbridge_dir_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StRampDown = 2'd2,
    StCoast    = 2'd3
  } state_e;

  function automatic logic is_driving(input state_e st);
    return (st == StRun) || (st == StRampDown);
  endfunction

  function automatic logic is_busy(input state_e st);
    return (st == StRampDown) || (st == StCoast);
  endfunction

endpackage

// File: rtl/hbridge_dir_sequencer_carrier.sv
// Free-running PWM carrier: period counter, duty comparator and end-of-period strobe.
module hbridge_dir_sequencer_carrier #(
  parameter int unsigned PWM_PERIOD = 100000,
  parameter int unsigned DUTY_W     = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty,
  input  logic              en,
  output logic              pwm,
  output logic              boundary
);

  localparam logic [DUTY_W-1:0] LastCnt = DUTY_W'(PWM_PERIOD - 1);

  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              pwm_q, pwm_d;

  always_comb begin
    cnt_d    = (cnt_q == LastCnt) ? '0 : cnt_q + DUTY_W'(1);
    pwm_d    = en && (cnt_q < duty);
    boundary = (cnt_q == LastCnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/hbridge_dir_sequencer.sv
// Direction-reversal sequencer: ramp down, coast, flip dir, ramp up; drives the PWM carrier.
module hbridge_dir_sequencer
  import hbridge_dir_sequencer_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = 100000,
  parameter int unsigned DUTY_W     = 17,
  parameter int unsigned RAMP_STEP  = 1000,
  parameter int unsigned COAST_CYC  = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_cmd,
  input  logic              dir_cmd,
  output logic              pwm_out,
  output logic              dir,
  output logic [DUTY_W-1:0] duty_cur,
  output logic              busy,
  output logic [1:0]        state
);

  localparam int unsigned DW1    = DUTY_W + 1;
  localparam int unsigned TimerW = (COAST_CYC > 1) ? $clog2(COAST_CYC) : 1;

  localparam logic [DW1-1:0]    Period    = DW1'(PWM_PERIOD);
  localparam logic [DW1-1:0]    Step      = DW1'(RAMP_STEP);
  localparam logic [TimerW-1:0] CoastLoad = TimerW'(COAST_CYC - 1);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;
  logic              busy_q, busy_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic              boundary;
  logic              carrier_en;
  logic [DW1-1:0]    cmd_ext, target, cur, up_sum, run_val, down_val;

  // Slew arithmetic is one bit wider so cur + Step cannot wrap.
  always_comb begin
    cmd_ext  = {1'b0, duty_cmd};
    target   = (cmd_ext > Period) ? Period : cmd_ext;
    cur      = {1'b0, duty_q};
    up_sum   = cur + Step;
    run_val  = cur;
    if (cur < target) begin
      run_val = (up_sum > target) ? target : up_sum;
    end else if (cur > target) begin
      run_val = ((cur - target) > Step) ? (cur - Step) : target;
    end
    down_val = (cur > Step) ? (cur - Step) : '0;
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    if (!enable) begin
      state_d = StIdle;
      duty_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StCoast;
          timer_d = CoastLoad;
          duty_d  = '0;
        end
        StCoast: begin
          duty_d = '0;
          if (timer_q == '0) begin
            dir_d   = dir_cmd;
            state_d = StRun;
          end else begin
            timer_d = timer_q - TimerW'(1);
          end
        end
        StRun: begin
          if (boundary) duty_d = run_val[DUTY_W-1:0];
          if (dir_cmd != dir_q) state_d = StRampDown;
        end
        StRampDown: begin
          if (boundary) duty_d = down_val[DUTY_W-1:0];
          if (dir_cmd == dir_q) begin
            state_d = StRun;
          end else if (boundary && (down_val == '0)) begin
            state_d = StCoast;
            timer_d = CoastLoad;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      timer_q <= timer_d;
    end
  end

  // Gating on enable makes the drop to IDLE kill pwm on the very next edge.
  assign carrier_en = enable && is_driving(state_q);

  hbridge_dir_sequencer_carrier #(
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_W     (DUTY_W)
  ) u_carrier (
    .clk      (clk),
    .rst      (rst),
    .duty     (duty_q),
    .en       (carrier_en),
    .pwm      (pwm_out),
    .boundary (boundary)
  );

  assign dir      = dir_q;
  assign duty_cur = duty_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule
